// File: rtl/memory_line_master_pkg.sv
// Shared types and constants for the cache-line memory master.
// State encoding, word geometry and a width helper used by the top and its counter.
package memory_line_master_pkg;

  localparam int REG_SIZE = 32;
  localparam int WIDTH    = 128;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    MLM_IDLE = 2'd0,
    MLM_WAIT = 2'd1,
    MLM_XFER = 2'd2,
    MLM_DONE = 2'd3
  } mlm_state_e;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_line_master_mem_wait_counter.sv
// Per-word latency counter: loads on start, counts down, flags done when it reaches zero.
// With LATENCY == 0 the owner never waits, so the load value collapses to zero.
module mem_wait_counter #(
  parameter int LATENCY = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_dec,
  output logic o_done
);

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  // The done cycle itself is one of the LATENCY wait cycles, hence the minus one.
  localparam logic [CW-1:0] LOAD = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= LOAD;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/memory_line_master.sv
// Cache-line initiator: splits one line fill or write-back into word accesses on a
// memory_sync-style port, with a fixed wait before every word, and returns the line.
module memory_line_master
  import memory_line_master_pkg::*;
#(
  parameter int LINE_WIDTH = WIDTH,
  parameter int LATENCY    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [REG_SIZE-1:0]   req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [LINE_WIDTH-1:0] rsp_rdata,
  output logic [REG_SIZE-1:0]   mem_addr,
  output logic                  mem_do_read,
  output logic                  mem_do_write,
  output logic                  mem_is_byte,
  output logic [REG_SIZE-1:0]   mem_data_in,
  input  logic [REG_SIZE-1:0]   mem_data_out
);

  localparam int NW       = LINE_WIDTH / WORD_W;
  localparam int IDXW     = idx_width(NW);
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [REG_SIZE-1:0] BASE_MASK = {REG_SIZE{1'b1}} << OFF_BITS;
  localparam logic [IDXW-1:0]     LAST_IDX  = IDXW'(NW - 1);
  localparam mlm_state_e          WORD_START = (LATENCY == 0) ? MLM_XFER : MLM_WAIT;

  mlm_state_e            r_state;
  mlm_state_e            w_next_state;
  logic                  r_alive;
  logic [REG_SIZE-1:0]   r_base;
  logic                  r_write;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_buf;
  logic [LINE_WIDTH-1:0] r_rsp_rdata;
  logic [IDXW-1:0]       r_idx;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_xfer;
  logic                  w_cnt_start;
  logic                  w_cnt_dec;
  logic                  w_cnt_done;
  logic [LINE_WIDTH-1:0] w_next_buf;

  mem_wait_counter #(.LATENCY(LATENCY)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_cnt_start),
    .i_dec   (w_cnt_dec),
    .o_done  (w_cnt_done)
  );

  // r_alive keeps req_ready low while in reset and lets it rise one edge after release.
  assign req_ready = r_alive && (r_state == MLM_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_xfer    = (r_state == MLM_XFER);
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MLM_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_cnt_start  = 1'b0;
    w_cnt_dec    = 1'b0;
    unique case (r_state)
      MLM_IDLE: begin
        if (w_accept) begin
          w_next_state = WORD_START;
          w_cnt_start  = 1'b1;
        end
      end
      MLM_WAIT: begin
        if (w_cnt_done) begin
          w_next_state = MLM_XFER;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      MLM_XFER: begin
        if (w_last) begin
          w_next_state = MLM_DONE;
        end else begin
          w_next_state = WORD_START;
          w_cnt_start  = 1'b1;
        end
      end
      MLM_DONE: w_next_state = MLM_IDLE;
      default:  w_next_state = MLM_IDLE;
    endcase
  end

  always_comb begin
    w_next_buf = r_buf;
    w_next_buf[r_idx*WORD_W +: WORD_W] = mem_data_out;
  end

  // NOTE: the line buffers are plain registers, not RAM, so they are reset like any
  // other flop; a reset mid-read must drop the partial line and clear rsp_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alive     <= 1'b0;
      r_base      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_rsp_rdata <= '0;
      r_idx       <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        r_base  <= req_addr & BASE_MASK;
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_idx   <= '0;
      end else if (w_xfer) begin
        if (!r_write) begin
          r_buf <= w_next_buf;
          if (w_last) begin
            r_rsp_rdata <= w_next_buf;
          end
        end
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // Base is line-aligned, so base + 4k never carries above the line offset.
  assign mem_addr     = r_base + (REG_SIZE'(r_idx) << 2);
  assign mem_do_read  = w_xfer && !r_write;
  assign mem_do_write = w_xfer && r_write;
  assign mem_is_byte  = 1'b0;
  assign mem_data_in  = (w_xfer && r_write) ? r_wdata[r_idx*WORD_W +: WORD_W] : '0;
  assign rsp_valid    = (r_state == MLM_DONE);
  assign rsp_rdata    = r_rsp_rdata;

endmodule

// File: tb/tb_memory_line_master.sv
// Bench for memory_line_master: a LATENCY=5 and a LATENCY=0 instance share a word memory;
// a line-level reference model predicts strobe timing, addresses, data and responses.
module tb_memory_line_master;

  localparam int NW = 4;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Suffix _a: LATENCY=5 instance, suffix _b: LATENCY=0 instance.
  logic         req_valid_a, req_ready_a, req_write_a, rsp_valid_a;
  logic         req_valid_b, req_ready_b, req_write_b, rsp_valid_b;
  logic [31:0]  req_addr_a, req_addr_b;
  logic [127:0] req_wdata_a, req_wdata_b, rsp_rdata_a, rsp_rdata_b;
  logic [31:0]  mem_addr_a, mem_data_in_a, mem_data_out_a;
  logic [31:0]  mem_addr_b, mem_data_in_b, mem_data_out_b;
  logic         rd_a, wr_a, byte_a, rd_b, wr_b, byte_b;

  memory_line_master #(.LINE_WIDTH(128), .LATENCY(5)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .mem_addr(mem_addr_a), .mem_do_read(rd_a), .mem_do_write(wr_a),
    .mem_is_byte(byte_a), .mem_data_in(mem_data_in_a), .mem_data_out(mem_data_out_a)
  );

  memory_line_master #(.LINE_WIDTH(128), .LATENCY(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .mem_addr(mem_addr_b), .mem_do_read(rd_b), .mem_do_write(wr_b),
    .mem_is_byte(byte_b), .mem_data_in(mem_data_in_b), .mem_data_out(mem_data_out_b)
  );

  // Word memory (memory_sync behaviour): combinational read, write on the clock edge.
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign mem_data_out_a = mem[mem_addr_a[9:2]];
  assign mem_data_out_b = mem[mem_addr_b[9:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (wr_a)   mem[mem_addr_a[9:2]] <= mem_data_in_a;
    if (wr_b)   mem[mem_addr_b[9:2]] <= mem_data_in_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  strobe_t sq_a[$], sq_b[$];
  rsp_t    rq_a[$], rq_b[$];
  int      mon_err = 0;

  always @(negedge clk) begin
    if ((rd_a && wr_a) || (rd_b && wr_b) || byte_a || byte_b) mon_err++;
    if (rd_a || wr_a) sq_a.push_back('{cyc, wr_a, mem_addr_a, mem_data_in_a});
    if (rd_b || wr_b) sq_b.push_back('{cyc, wr_b, mem_addr_b, mem_data_in_b});
    if (rsp_valid_a) rq_a.push_back('{cyc, rsp_rdata_a});
    if (rsp_valid_b) rq_b.push_back('{cyc, rsp_rdata_b});
  end

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [31:0]  ref_mem [0:255];
  logic [127:0] exp_rd_a = '0, exp_rd_b = '0;
  int           ps_a = 0, ps_b = 0, pr_a = 0, pr_b = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = idx[7:0];
    pre_data = d;
    ref_mem[idx] = d;
  endtask

  task automatic poke_done();
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Present a request to instance a (sel=1) or b (sel=0); returns cyc during cycle 1.
  task automatic issue(input bit sel, input bit wr, input logic [31:0] addr,
                       input logic [127:0] wd, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? req_ready_a : req_ready_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", sel ? req_ready_a : req_ready_b, 1);
    if (sel) begin
      req_valid_a = 1'b1; req_write_a = wr; req_addr_a = addr; req_wdata_a = wd;
    end else begin
      req_valid_b = 1'b1; req_write_b = wr; req_addr_b = addr; req_wdata_b = wd;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    // Inputs are only sampled at accept, so scramble them afterwards.
    if (sel) begin
      req_valid_a = 1'b0; req_write_a = ~wr; req_addr_a = $urandom; req_wdata_a = {4{$urandom}};
    end else begin
      req_valid_b = 1'b0; req_write_b = ~wr; req_addr_b = $urandom; req_wdata_b = {4{$urandom}};
    end
  endtask

  // Line-level expectation: word k strobes in cycle (k+1)*(L+1), response in NW*(L+1)+1.
  task automatic verify(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [127:0] wd, input int acc);
    int           lat, total, ps, pr, bidx;
    logic [31:0]  base;
    logic [127:0] exp_line;
    strobe_t      q[$];
    rsp_t         r[$];
    lat   = sel ? 5 : 0;
    total = NW * (lat + 1) + 1;
    base  = addr & 32'hFFFF_FFF0;
    bidx  = int'(base[9:2]);
    while (cyc < acc + total + 2) @(negedge clk);
    q  = sel ? sq_a : sq_b;
    r  = sel ? rq_a : rq_b;
    ps = sel ? ps_a : ps_b;
    pr = sel ? pr_a : pr_b;
    check("strobe_count", q.size() - ps, NW);
    for (int k = 0; k < NW; k++) begin
      if (ps + k < q.size()) begin
        check("strobe_cycle", q[ps+k].cyc, acc + (k + 1) * (lat + 1) - 1);
        check("strobe_dir", q[ps+k].wr, wr);
        check("strobe_addr", q[ps+k].addr, base + 32'(4 * k));
        if (wr) check("strobe_wdata", q[ps+k].data, wd[32*k +: 32]);
      end
    end
    if (wr) begin
      exp_line = sel ? exp_rd_a : exp_rd_b;
      for (int k = 0; k < NW; k++) ref_mem[bidx + k] = wd[32*k +: 32];
    end else begin
      for (int k = 0; k < NW; k++) exp_line[32*k +: 32] = ref_mem[bidx + k];
      if (sel) exp_rd_a = exp_line; else exp_rd_b = exp_line;
    end
    check("rsp_count", r.size() - pr, 1);
    if (pr < r.size()) begin
      check("rsp_cycle", r[pr].cyc, acc + total - 1);
      check("rsp_rdata_at_pulse", r[pr].data, exp_line);
    end
    check("rsp_rdata_held", sel ? rsp_rdata_a : rsp_rdata_b, exp_line);
    if (sel) begin ps_a = q.size(); pr_a = r.size(); end
    else     begin ps_b = q.size(); pr_b = r.size(); end
  endtask

  task automatic do_req(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [127:0] wd);
    int acc;
    issue(sel, wr, addr, wd, acc);
    verify(sel, wr, addr, wd, acc);
  endtask

  initial begin
    int           acc1, acc2, nbad;
    logic [127:0] w_line;
    logic [31:0]  r_addr;
    bit           r_sel, r_wr;

    reset = 1'b0;
    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 32'h104; req_wdata_a = '1;
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 32'h104; req_wdata_b = '1;

    // 1. Reset held with requests pending: everything 0, no strobes.
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(32'h40, 32'h11111111); poke(32'h41, 32'h22222222);
    poke(32'h42, 32'h33333333); poke(32'h43, 32'h44444444);
    poke_done();
    check("reset_ctrl_a", {req_ready_a, rsp_valid_a, rd_a, wr_a, byte_a, mem_addr_a, mem_data_in_a}, 0);
    check("reset_ctrl_b", {req_ready_b, rsp_valid_b, rd_b, wr_b, byte_b, mem_addr_b, mem_data_in_b}, 0);
    check("reset_rdata", {rsp_rdata_a, rsp_rdata_b}, 0);
    check("reset_no_strobes", sq_a.size() + sq_b.size() + rq_a.size() + rq_b.size(), 0);
    reset = 1'b1;
    #1;
    check("ready_at_release", {req_ready_a, req_ready_b}, 2'b00);
    @(negedge clk);
    check("ready_after_release", {req_ready_a, req_ready_b}, 2'b11);
    req_valid_a = 1'b0; req_valid_b = 1'b0;

    // 2. LATENCY=5 line fill from an unaligned address.
    do_req(1'b1, 1'b0, 32'h104, '0);
    check("t2_line", rsp_rdata_a, 128'h44444444_33333333_22222222_11111111);

    // 3. Write-back, then read the line back.
    w_line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    do_req(1'b1, 1'b1, 32'h20C, w_line);
    check("t3_rdata_unchanged", rsp_rdata_a, 128'h44444444_33333333_22222222_11111111);
    do_req(1'b1, 1'b0, 32'h200, '0);
    check("t3_readback", rsp_rdata_a, w_line);

    // 4. Second request held while busy: accepted only in the IDLE cycle after DONE.
    w_line = {$urandom, $urandom, $urandom, $urandom};
    issue(1'b1, 1'b1, 32'h304, w_line, acc1);
    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 32'h308;
    while (cyc < acc1 + 25) begin
      @(negedge clk);
      if (cyc == acc1 + 9 || cyc == acc1 + 24) check("busy_ready_low", req_ready_a, 0);
    end
    check("idle_ready_high", req_ready_a, 1);
    @(posedge clk);
    #1;
    acc2 = cyc;
    req_valid_a = 1'b0;
    verify(1'b1, 1'b1, 32'h304, w_line, acc1);
    verify(1'b1, 1'b0, 32'h308, '0, acc2);
    check("t4_readback", rsp_rdata_a, w_line);

    // 5. Reset during word 2's wait of a write-back.
    w_line = {$urandom, $urandom, $urandom, $urandom};
    issue(1'b1, 1'b1, 32'h200, w_line, acc1);
    while (cyc < acc1 + 13) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ctrl", {req_ready_a, rsp_valid_a, rd_a, wr_a, byte_a, mem_addr_a, mem_data_in_a}, 0);
    check("abort_rdata", rsp_rdata_a, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_strobes", sq_a.size() - ps_a, 2);
    check("abort_no_rsp", rq_a.size() - pr_a, 0);
    check("abort_word2_kept", mem[32'h82], ref_mem[32'h82]);
    check("abort_word3_kept", mem[32'h83], ref_mem[32'h83]);
    ref_mem[32'h80] = w_line[31:0];
    ref_mem[32'h81] = w_line[63:32];
    ps_a = sq_a.size(); pr_a = rq_a.size();
    exp_rd_a = '0; exp_rd_b = '0;

    // 6. LATENCY=0: back-to-back word reads, response in cycle 5.
    do_req(1'b0, 1'b0, 32'h10C, '0);

    // Randomized mix against the reference model.
    for (int i = 0; i < 12; i++) begin
      r_sel  = 1'($urandom_range(0, 1));
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = $urandom & 32'h3FF;
      w_line = {$urandom, $urandom, $urandom, $urandom};
      do_req(r_sel, r_wr, r_addr, w_line);
    end

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("memory_image", nbad, 0);
    check("monitor_rules", mon_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
